// File: rtl/ksa_sub_pipe_32b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ksa_pkg
// Description : Shared constants, prefix spans and the per-bit generate /
//               propagate pair type for the pipelined Kogge-Stone subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package ksa_pkg;

  localparam int KSA_W         = 32;
  localparam int KSA_LEVELS    = 5;
  // Number of prefix levels evaluated ahead of the S2 register; the rest
  // sit between S2 and S3.
  localparam int KSA_S2_LEVELS = 3;

  localparam int KSA_SPAN_L0   = 1;
  localparam int KSA_SPAN_L1   = 2;
  localparam int KSA_SPAN_L2   = 4;
  localparam int KSA_SPAN_L3   = 8;
  localparam int KSA_SPAN_L4   = 16;

  typedef struct packed {
    logic g;
    logic p;
  } ksa_pg_t;

  // Distance between the two operands of a black cell at a given level.
  function automatic int ksa_span(input int lvl);
    return 1 << lvl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ksa_prefix_cell.sv
`default_nettype none
// ============================================================================
// Module      : ksa_prefix_cell
// Description : Kogge-Stone black cell, merges a high and a low group
//               generate/propagate pair.
// Revision    : 1.0 - initial release
// ============================================================================
module ksa_prefix_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;

endmodule
`default_nettype wire

// File: rtl/ksa_sub_pipe_32b.sv
`default_nettype none
// ============================================================================
// Module      : ksa_sub_pipe_32b
// Description : Three-stage pipelined 32-bit Kogge-Stone subtractor computing
//               a - b - bin with valid/ready handshakes on both sides.
//               Optional macro KSA_SUB_SAT_EN saturates the difference on
//               signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module ksa_sub_pipe_32b
  import ksa_pkg::*;
#(
  parameter int W = KSA_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_bin,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_d,
  output logic         o_borrow,
  output logic         o_ovf
);

  logic v1_q, v2_q, v3_q;
  logic w_ld1, w_ld2, w_ld3;
  logic w_en1, w_en2, w_en3;

  ksa_pg_t [KSA_W-1:0] w_s1_pg;
  ksa_pg_t [KSA_W-1:0] s1_pg_q;
  logic                s1_c0_q, s1_a31_q, s1_b31_q;

  ksa_pg_t [KSA_W-1:0] w_s2_grp;
  ksa_pg_t [KSA_W-1:0] s2_grp_q;
  logic    [KSA_W-1:0] s2_p_q;
  logic                s2_c0_q, s2_a31_q, s2_b31_q;

  logic    [KSA_W-1:0] w_g0, w_p0, w_s2_g, w_s2_p, w_raw_p;
  logic    [KSA_W-1:0] w_diff, w_d3, w_carry;
  logic                w_cout, w_ovf;
  logic                w_unused;

  logic    [KSA_W-1:0] d_q;
  logic                borrow_q, ovf_q;

  // Ready chain: a stage may load when empty or when its successor loads.
  always_comb begin
    w_ld3   = ~v3_q | i_ready;
    w_ld2   = ~v2_q | w_ld3;
    w_ld1   = ~v1_q | w_ld2;
    o_ready = i_rst_n & (~v1_q | ~v2_q | ~v3_q | i_ready);
    w_en1   = w_ld1 & i_valid;
    w_en2   = w_ld2 & v1_q;
    w_en3   = w_ld3 & v2_q;
  end

  // Stage valid bits move forward whenever the stage loads.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (w_ld1) v1_q <= i_valid;
      if (w_ld2) v2_q <= v1_q;
      if (w_ld3) v3_q <= v2_q;
    end
  end

  // Bitwise generate/propagate of a + ~b.
  always_comb begin
    w_s1_pg = '0;
    for (int i = 0; i < KSA_W; i++) begin
      w_s1_pg[i].g = i_a[i] & ~i_b[i];
      w_s1_pg[i].p = i_a[i] ^ ~i_b[i];
    end
  end

  // S1: bitwise terms, carry-in and operand sign bits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_pg_q  <= '0;
      s1_c0_q  <= 1'b0;
      s1_a31_q <= 1'b0;
      s1_b31_q <= 1'b0;
    end else if (w_en1) begin
      s1_pg_q  <= w_s1_pg;
      s1_c0_q  <= ~i_bin;
      s1_a31_q <= i_a[KSA_W-1];
      s1_b31_q <= i_b[KSA_W-1];
    end
  end

  // Unpack S1 and fold the carry-in into bit 0 so the 5-level tree yields
  // the carry out of every bit directly.
  always_comb begin
    w_g0 = '0;
    w_p0 = '0;
    for (int i = 0; i < KSA_W; i++) begin
      w_g0[i] = s1_pg_q[i].g;
      w_p0[i] = s1_pg_q[i].p;
    end
    w_raw_p = w_p0;
    w_g0[0] = s1_pg_q[0].g | (s1_pg_q[0].p & s1_c0_q);
  end

  // Prefix tree; levels below KSA_S2_LEVELS feed the S2 register, the
  // remaining levels read from it.
  for (genvar l = 0; l < KSA_LEVELS; l++) begin : g_lvl
    logic [KSA_W-1:0] w_gi, w_pi, w_go, w_po;
    if (l == 0) begin : g_src_s1
      assign w_gi = w_g0;
      assign w_pi = w_p0;
    end else if (l == KSA_S2_LEVELS) begin : g_src_s2
      assign w_gi = w_s2_g;
      assign w_pi = w_s2_p;
    end else begin : g_src_prev
      assign w_gi = g_lvl[l-1].w_go;
      assign w_pi = g_lvl[l-1].w_po;
    end
    for (genvar i = 0; i < KSA_W; i++) begin : g_bit
      if (i >= ksa_span(l)) begin : g_cell
        ksa_prefix_cell u_cell (
          .g_hi_i (w_gi[i]),
          .p_hi_i (w_pi[i]),
          .g_lo_i (w_gi[i-ksa_span(l)]),
          .p_lo_i (w_pi[i-ksa_span(l)]),
          .g_o    (w_go[i]),
          .p_o    (w_po[i])
        );
      end else begin : g_pass
        assign w_go[i] = w_gi[i];
        assign w_po[i] = w_pi[i];
      end
    end
  end

  // Pack/unpack the group terms around the S2 register.
  always_comb begin
    w_s2_grp = '0;
    w_s2_g   = '0;
    w_s2_p   = '0;
    for (int i = 0; i < KSA_W; i++) begin
      w_s2_grp[i].g = g_lvl[KSA_S2_LEVELS-1].w_go[i];
      w_s2_grp[i].p = g_lvl[KSA_S2_LEVELS-1].w_po[i];
      w_s2_g[i]     = s2_grp_q[i].g;
      w_s2_p[i]     = s2_grp_q[i].p;
    end
  end

  // S2: partial group terms plus the raw bit propagates needed for the sum.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_grp_q <= '0;
      s2_p_q   <= '0;
      s2_c0_q  <= 1'b0;
      s2_a31_q <= 1'b0;
      s2_b31_q <= 1'b0;
    end else if (w_en2) begin
      s2_grp_q <= w_s2_grp;
      s2_p_q   <= w_raw_p;
      s2_c0_q  <= s1_c0_q;
      s2_a31_q <= s1_a31_q;
      s2_b31_q <= s1_b31_q;
    end
  end

  // Sum, borrow-out, overflow and optional saturation ahead of S3.
  always_comb begin
    w_carry = {g_lvl[KSA_LEVELS-1].w_go[KSA_W-2:0], s2_c0_q};
    w_diff  = s2_p_q ^ w_carry;
    w_cout  = g_lvl[KSA_LEVELS-1].w_go[KSA_W-1];
    w_ovf   = (s2_a31_q != s2_b31_q) & (w_diff[KSA_W-1] != s2_a31_q);
`ifdef KSA_SUB_SAT_EN
    if (w_ovf) begin
      w_d3 = s2_a31_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      w_d3 = w_diff;
    end
`else
    w_d3 = w_diff;
`endif
  end

  // Final-level group propagates have no consumer.
  assign w_unused = ^g_lvl[KSA_LEVELS-1].w_po;

  // S3: result register driving the outputs directly.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      d_q      <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (w_en3) begin
      d_q      <= w_d3;
      borrow_q <= ~w_cout;
      ovf_q    <= w_ovf;
    end
  end

  assign o_valid  = v3_q;
  assign o_d      = d_q;
  assign o_borrow = borrow_q;
  assign o_ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ksa_sub_pipe_32b.sv
`default_nettype none
// ============================================================================
// Module      : tb_ksa_sub_pipe_32b
// Description : Self-checking bench for ksa_sub_pipe_32b: directed corner
//               cases, a stalled stream, randomized handshakes and a
//               mid-flight reset, all scored against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ksa_sub_pipe_32b;

  logic        clk = 1'b0;
  logic        i_rst_n, i_valid, i_bin, i_ready;
  logic [31:0] i_a, i_b;
  logic        o_ready, o_valid, o_borrow, o_ovf;
  logic [31:0] o_d;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q [$];

  always #5 clk = ~clk;

  ksa_sub_pipe_32b #(.W(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_bin    (i_bin),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_d      (o_d),
    .o_borrow (o_borrow),
    .o_ovf    (o_ovf)
  );

  // Expected {ovf, borrow, d} from plain integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic bin);
    logic [32:0] u;
    longint      sa, sb, s, dw;
    logic [31:0] d;
    logic        ovf;
    u   = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    sa  = $signed(a);
    sb  = $signed(b);
    s   = sa - sb - longint'(bin);
    d   = u[31:0];
    dw  = $signed(d);
    ovf = (s != dw);
`ifdef KSA_SUB_SAT_EN
    if (ovf) d = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ovf, u[32], d};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = 32'h0000_0000;
      1: r = 32'hFFFF_FFFF;
      2: r = 32'h8000_0000;
      3: r = 32'h7FFF_FFFF;
      default: ;
    endcase
    return r;
  endfunction

  // Scoreboard: record accepted operands, check every emitted result in
  // order, and require held outputs while stalled.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_b, prev_o;
  always @(negedge clk) begin
    logic [33:0] e;
    if (i_rst_n) begin
      if (prev_stall) begin
        check("stall_d", o_d, prev_d);
        check("stall_borrow", 32'(o_borrow), 32'(prev_b));
        check("stall_ovf", 32'(o_ovf), 32'(prev_o));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got o_d=0x%08h expected no output", o_d);
        end else begin
          e = exp_q.pop_front();
          check("sb_d", o_d, e[31:0]);
          check("sb_borrow", 32'(o_borrow), 32'(e[32]));
          check("sb_ovf", 32'(o_ovf), 32'(e[33]));
        end
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_a, i_b, i_bin));
      prev_stall = o_valid & ~i_ready;
      prev_d     = o_d;
      prev_b     = o_borrow;
      prev_o     = o_ovf;
    end else begin
      exp_q.delete();
      prev_stall = 1'b0;
    end
  end

  // One operation through an empty pipe with literal expectations.
  task automatic run_directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input logic bin, input logic [31:0] ed, input logic eb,
                              input logic eo);
    int lat;
    @(posedge clk); #1;
    i_a = a; i_b = b; i_bin = bin; i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    check({nm, "_ready"}, 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'd3);
    check({nm, "_d"}, o_d, ed);
    check({nm, "_borrow"}, 32'(o_borrow), 32'(eb));
    check({nm, "_ovf"}, 32'(o_ovf), 32'(eo));
    @(posedge clk); #1;
    check({nm, "_one_cycle"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    int  sent;
    logic acc, saw_low;

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_a = '0; i_b = '0; i_bin = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_d", o_d, 32'd0);
    check("rst_borrow", 32'(o_borrow), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(o_ready), 32'd1);

    // Directed corners
    run_directed("sub_5_3", 32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0);
    run_directed("sub_0_1", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_directed("sub_ff_ff_bin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
`ifdef KSA_SUB_SAT_EN
    run_directed("ovf_neg", 32'h8000_0000, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_directed("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
`else
    run_directed("ovf_neg", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_directed("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
`endif

    // Stream of 8 with a 4-cycle downstream stall
    sent = 0; acc = 1'b0; saw_low = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (acc) sent++;
      if (sent < 8) begin
        if (acc || !i_valid) begin
          i_a = $urandom; i_b = $urandom; i_bin = 1'($urandom_range(0, 1));
        end
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      i_ready = !(c >= 4 && c < 8);
      @(negedge clk);
      acc = i_valid & o_ready;
      if (!i_ready && !o_ready) saw_low = 1'b1;
    end
    check("stream_sent", 32'(sent), 32'd8);
    check("stream_ready_drop", 32'(saw_low), 32'd1);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Randomized operands and handshakes on both sides
    acc = 1'b0;
    i_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (acc || !i_valid) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_a = rnd_word(); i_b = rnd_word(); i_bin = 1'($urandom_range(0, 1));
      end
      i_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = i_valid & o_ready;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three operations in flight
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      i_valid = 1'b1; i_a = $urandom; i_b = $urandom; i_bin = 1'b0; i_ready = 1'b1;
      @(negedge clk);
      check("flight_ready", 32'(o_ready), 32'd1);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready_low", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_d", o_d, 32'd0);
    check("midrst_borrow", 32'(o_borrow), 32'd0);
    check("midrst_ovf", 32'(o_ovf), 32'd0);
    check("midrst_ready_high", 32'(o_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale", 32'(o_valid), 32'd0);
    end

    // Pipelined result after reset still correct
    run_directed("after_rst", 32'd100, 32'd58, 1'b1, 32'd41, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
